phase_sequencer: RTL and testbench

Parametrised instruction-phase controller for the CPU core. It steps a phase counter through NUM_PHASES phases per instruction and gates selected phases on a ready handshake. It supports stall, flush, halt/resume at instruction boundaries, a per-phase wait timeout and a retired-instruction counter. With NUM_PHASES=2 and READY_MASK=0 it reproduces the two-phase INSTR/DATA alternation, where instr_phase is high in phase 0.

---
 rtl/phase_sequencer_pkg.sv | 16 +
 rtl/phase_sequencer_wait_timer.sv | 35 +++
 rtl/phase_sequencer.sv | 138 +++++++++++++
 tb/tb_phase_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// rtl/phase_sequencer_pkg.sv - shared types and constants for the phase sequencer
package phase_sequencer_pkg;

    typedef enum logic {
        CTRL_RUN    = 1'b0,
        CTRL_HALTED = 1'b1
    } ctrl_state_t;

    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_MEM    = 3;

    localparam logic [3:0] DEFAULT_READY_MASK = 4'b1000;

endpackage

// File: rtl/phase_sequencer_wait_timer.sv
// rtl/phase_sequencer_wait_timer.sv - wait-cycle counter with timeout compare
module phase_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Fires in the cycle whose count would reach TIMEOUT, so the owner reacts on that edge.
    assign expired = count_en && (count_q == 8'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (count_en) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - instruction phase controller with ready gating, halt and timeout
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int                    NUM_PHASES = 4,
    parameter logic [NUM_PHASES-1:0] READY_MASK = '0,
    parameter int                    TIMEOUT    = 15,
    parameter int                    CNT_W      = 32,
    localparam int                   PW         = $clog2(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  phase_ready,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic [PW-1:0]         phase,
    output logic [NUM_PHASES-1:0] phase_onehot,
    output logic                  instr_phase,
    output logic                  first_cycle,
    output logic                  retire,
    output logic [CNT_W-1:0]      retire_count,
    output logic                  halted,
    output logic                  timeout_err
);

    ctrl_state_t      state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             first_q, first_d;
    logic             retire_q, retire_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             terr_q, terr_d;

    logic gated;
    logic adv;
    logic last;
    logic run;
    logic wait_en;
    logic wait_clear;
    logic expired;

    assign run     = (state_q == CTRL_RUN);
    assign gated   = READY_MASK[phase_q];
    assign adv     = !stall && (!gated || phase_ready);
    assign last    = (phase_q == PW'(NUM_PHASES - 1));
    assign wait_en = run && gated && !stall && !phase_ready;
    // Any phase change (advance, flush, timeout) or leaving RUN restarts the wait count.
    assign wait_clear = !run || flush || adv || expired;

    phase_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .count_en (wait_en),
        .clear    (wait_clear),
        .expired  (expired)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        first_d  = 1'b0;
        retire_d = 1'b0;
        count_d  = count_q;
        terr_d   = terr_q;
        case (state_q)
            CTRL_RUN: begin
                if (flush) begin
                    phase_d = PW'(PH_FETCH);
                    first_d = 1'b1;
                end else if (expired) begin
                    terr_d  = 1'b1;
                    state_d = CTRL_HALTED;
                    phase_d = PW'(PH_FETCH);
                    first_d = (phase_q != PW'(PH_FETCH));
                end else if (adv) begin
                    first_d = 1'b1;
                    if (last) begin
                        phase_d  = PW'(PH_FETCH);
                        retire_d = 1'b1;
                        count_d  = count_q + CNT_W'(1);
                        if (halt_req) begin
                            state_d = CTRL_HALTED;
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            CTRL_HALTED: begin
                if (resume) begin
                    state_d = CTRL_RUN;
                    first_d = 1'b1;
                end
            end
            default: begin
                state_d = CTRL_RUN;
                phase_d = PW'(PH_FETCH);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CTRL_RUN;
            phase_q  <= PW'(PH_FETCH);
            first_q  <= 1'b1;
            retire_q <= 1'b0;
            count_q  <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            first_q  <= first_d;
            retire_q <= retire_d;
            count_q  <= count_d;
            terr_q   <= terr_d;
        end
    end

    always_comb begin
        phase_onehot = '0;
        if (run) begin
            phase_onehot[phase_q] = 1'b1;
        end
    end

    assign instr_phase  = phase_onehot[0];
    assign phase        = phase_q;
    assign first_cycle  = first_q;
    assign retire       = retire_q;
    assign retire_count = count_q;
    assign halted       = (state_q == CTRL_HALTED);
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed vector bench for phase_sequencer
module tb_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Instance A: two-phase, ungated, 3-bit retire counter
    logic       a_rst = 1'b1;
    logic       a_stall = 1'b0, a_flush = 1'b0, a_ready = 1'b0, a_halt = 1'b0, a_resume = 1'b0;
    logic [0:0] a_phase;
    logic [1:0] a_onehot;
    logic       a_instr, a_first, a_retire, a_halted, a_terr;
    logic [2:0] a_count;

    phase_sequencer #(
        .NUM_PHASES (2),
        .READY_MASK (2'b00),
        .TIMEOUT    (15),
        .CNT_W      (3)
    ) u_a (
        .clk          (clk),
        .rst          (a_rst),
        .stall        (a_stall),
        .flush        (a_flush),
        .phase_ready  (a_ready),
        .halt_req     (a_halt),
        .resume       (a_resume),
        .phase        (a_phase),
        .phase_onehot (a_onehot),
        .instr_phase  (a_instr),
        .first_cycle  (a_first),
        .retire       (a_retire),
        .retire_count (a_count),
        .halted       (a_halted),
        .timeout_err  (a_terr)
    );

    // Instance B: four phases, phase 3 gated, TIMEOUT=4
    logic        b_rst = 1'b1;
    logic        b_stall = 1'b0, b_flush = 1'b0, b_ready = 1'b0, b_halt = 1'b0, b_resume = 1'b0;
    logic [1:0]  b_phase;
    logic [3:0]  b_onehot;
    logic        b_instr, b_first, b_retire, b_halted, b_terr;
    logic [31:0] b_count;

    phase_sequencer #(
        .NUM_PHASES (4),
        .READY_MASK (4'b1000),
        .TIMEOUT    (4),
        .CNT_W      (32)
    ) u_b (
        .clk          (clk),
        .rst          (b_rst),
        .stall        (b_stall),
        .flush        (b_flush),
        .phase_ready  (b_ready),
        .halt_req     (b_halt),
        .resume       (b_resume),
        .phase        (b_phase),
        .phase_onehot (b_onehot),
        .instr_phase  (b_instr),
        .first_cycle  (b_first),
        .retire       (b_retire),
        .retire_count (b_count),
        .halted       (b_halted),
        .timeout_err  (b_terr)
    );

    typedef struct {
        logic st, fl, rdy, hr, rs;
        int   ph, oh, fc, ret, cnt, hlt, terr;
    } vec_t;

    vec_t vecs[32];

    function automatic vec_t mk(input logic st, fl, rdy, hr, rs,
                                input int ph, oh, fc, ret, cnt, hlt, terr);
        vec_t v;
        v.st = st; v.fl = fl; v.rdy = rdy; v.hr = hr; v.rs = rs;
        v.ph = ph; v.oh = oh; v.fc = fc; v.ret = ret; v.cnt = cnt; v.hlt = hlt; v.terr = terr;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_b_reset(input string tag);
        check({tag, " phase"}, b_phase, 0);
        check({tag, " onehot"}, b_onehot, 1);
        check({tag, " instr_phase"}, b_instr, 1);
        check({tag, " first_cycle"}, b_first, 1);
        check({tag, " retire"}, b_retire, 0);
        check({tag, " retire_count"}, b_count, 0);
        check({tag, " halted"}, b_halted, 0);
        check({tag, " timeout_err"}, b_terr, 0);
    endtask

    initial begin
        // -------- Instance A: two-phase alternation and counter wrap --------
        step();
        a_rst = 1'b0;
        check("a reset phase", a_phase, 0);
        check("a reset first_cycle", a_first, 1);
        check("a reset retire_count", a_count, 0);
        check("a reset halted", a_halted, 0);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("a phase c%0d", k), a_phase, k % 2);
            check($sformatf("a instr_phase c%0d", k), a_instr, (k % 2 == 0) ? 1 : 0);
            step();
        end
        check("a retire_count after 3 instr", a_count, 3);
        for (int k = 6; k < 18; k++) begin
            check($sformatf("a retire_count c%0d", k), a_count, (k / 2) % 8);
            check($sformatf("a retire c%0d", k), a_retire, (k % 2 == 0) ? 1 : 0);
            step();
        end
        check("a retire_count wrapped", a_count, 1);
        check("a phase after 9 instr", a_phase, 0);
        step();
        check("a mid-instr phase", a_phase, 1);
        a_rst = 1'b1;
        step();
        check("a mid reset phase", a_phase, 0);
        check("a mid reset first_cycle", a_first, 1);
        check("a mid reset retire", a_retire, 0);
        check("a mid reset retire_count", a_count, 0);
        check("a mid reset onehot", a_onehot, 1);
        check("a mid reset timeout_err", a_terr, 0);

        // -------- Instance B: table-driven vectors --------
        vecs[0]  = mk(0,0,0,0,0, 1,2,1,0,0,0,0);
        vecs[1]  = mk(0,0,0,0,0, 2,4,1,0,0,0,0);
        vecs[2]  = mk(0,0,0,0,0, 3,8,1,0,0,0,0);
        vecs[3]  = mk(0,0,0,0,0, 3,8,0,0,0,0,0);
        vecs[4]  = mk(0,0,0,0,0, 3,8,0,0,0,0,0);
        vecs[5]  = mk(0,0,0,0,0, 3,8,0,0,0,0,0);
        vecs[6]  = mk(0,0,1,0,0, 0,1,1,1,1,0,0);
        vecs[7]  = mk(0,0,0,0,0, 1,2,1,0,1,0,0);
        vecs[8]  = mk(1,0,0,0,0, 1,2,0,0,1,0,0);
        vecs[9]  = mk(1,0,0,0,0, 1,2,0,0,1,0,0);
        vecs[10] = mk(1,0,0,0,0, 1,2,0,0,1,0,0);
        vecs[11] = mk(1,0,0,0,0, 1,2,0,0,1,0,0);
        vecs[12] = mk(1,0,0,0,0, 1,2,0,0,1,0,0);
        vecs[13] = mk(0,0,0,0,0, 2,4,1,0,1,0,0);
        vecs[14] = mk(0,1,0,0,0, 0,1,1,0,1,0,0);
        vecs[15] = mk(0,0,0,0,0, 1,2,1,0,1,0,0);
        vecs[16] = mk(0,0,0,1,0, 2,4,1,0,1,0,0);
        vecs[17] = mk(0,0,0,0,0, 3,8,1,0,1,0,0);
        vecs[18] = mk(0,0,1,1,0, 0,0,1,1,2,1,0);
        vecs[19] = mk(1,1,1,1,0, 0,0,0,0,2,1,0);
        vecs[20] = mk(0,0,0,1,1, 0,1,1,0,2,0,0);
        vecs[21] = mk(0,0,0,0,0, 1,2,1,0,2,0,0);
        vecs[22] = mk(0,0,0,0,0, 2,4,1,0,2,0,0);
        vecs[23] = mk(0,0,0,0,0, 3,8,1,0,2,0,0);
        vecs[24] = mk(0,0,0,0,0, 3,8,0,0,2,0,0);
        vecs[25] = mk(1,0,0,0,0, 3,8,0,0,2,0,0);
        vecs[26] = mk(0,0,0,0,0, 3,8,0,0,2,0,0);
        vecs[27] = mk(1,0,0,0,0, 3,8,0,0,2,0,0);
        vecs[28] = mk(0,0,0,0,0, 3,8,0,0,2,0,0);
        vecs[29] = mk(0,0,0,0,0, 0,0,1,0,2,1,1);
        vecs[30] = mk(0,0,0,0,1, 0,1,1,0,2,0,1);
        vecs[31] = mk(0,0,0,0,0, 1,2,1,0,2,0,1);

        step();
        b_rst = 1'b0;
        check_b_reset("b reset");
        for (int i = 0; i < 32; i++) begin
            b_stall  = vecs[i].st;
            b_flush  = vecs[i].fl;
            b_ready  = vecs[i].rdy;
            b_halt   = vecs[i].hr;
            b_resume = vecs[i].rs;
            step();
            check($sformatf("b v%0d phase", i), b_phase, vecs[i].ph);
            check($sformatf("b v%0d onehot", i), b_onehot, vecs[i].oh);
            check($sformatf("b v%0d instr_phase", i), b_instr, vecs[i].oh & 1);
            check($sformatf("b v%0d first_cycle", i), b_first, vecs[i].fc);
            check($sformatf("b v%0d retire", i), b_retire, vecs[i].ret);
            check($sformatf("b v%0d retire_count", i), b_count, vecs[i].cnt);
            check($sformatf("b v%0d halted", i), b_halted, vecs[i].hlt);
            check($sformatf("b v%0d timeout_err", i), b_terr, vecs[i].terr);
        end

        // Sticky timeout flag and in-flight instruction both cleared by reset
        b_stall = 1'b0; b_flush = 1'b0; b_ready = 1'b0; b_halt = 1'b0; b_resume = 1'b0;
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        check_b_reset("b mid reset");

        // Holding in the gated phase long after reset release still times out after 4 waits
        for (int k = 0; k < 3; k++) step();
        check("b gated entry phase", b_phase, 3);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("b wait %0d no timeout", k + 1), b_terr, 0);
        end
        step();
        check("b timeout after 4 waits", b_terr, 1);
        check("b halted on timeout", b_halted, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
